// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller:
// the hex glyph table, the per-digit record and the blank segment pattern.
package sevenseg_pkg;

  typedef struct packed {
    logic       en;
    logic       dp;
    logic [3:0] num;
  } digit_t;

  // Active-high {g,f,e,d,c,b,a}, element 0 is glyph '0'.
  localparam logic [15:0][6:0] HEX_TO_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF     = 7'h00;
  localparam digit_t     DIGIT_RESET = '{en: 1'b0, dp: 1'b0, num: 4'h0};

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment glyph decoder.
import sevenseg_pkg::*;

module sevenseg_hex_decode (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_TO_SEG[hex_i];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment display driver with brightness PWM.
// Define SEVENSEG_LZ_BLANK_EN to build in leading-zero blanking.
import sevenseg_pkg::*;

module sevenseg_scan_ctrl #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int REFRESH_DIV = 100000,
  parameter  bit ACTIVE_LOW  = 1'b1,
  localparam int SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [SEL_W-1:0]      sel,
  input  logic [3:0]            num,
  input  logic                  dp_in,
  input  logic                  clear,
  input  logic [2:0]            bright,
  output logic [6:0]            led,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] segment
);

  localparam int PW = $clog2(REFRESH_DIV);

  digit_t                digits_q [NUM_DIGITS];
  digit_t                digits_d [NUM_DIGITS];
  logic [PW-1:0]         presc_q, presc_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [6:0]            led_q, led_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] seg_q, seg_d;

  digit_t                cur;
  logic [6:0]            glyph;
  logic [31:0]           lit_limit;
  logic                  in_window;
  logic                  blanked;
  logic                  lit;
  logic [NUM_DIGITS-1:0] anode_ah;

  assign cur = digits_q[idx_q];

  sevenseg_hex_decode u_decode (
    .hex_i (cur.num),
    .seg_o (glyph)
  );

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_run;

  // A digit is a leading zero while every digit above it is an enabled bare zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run && digits_q[k].en && (digits_q[k].num == 4'h0) && !digits_q[k].dp;
      blank_vec[k] = zero_run;
    end
  end

  assign blanked = blank_vec[idx_q];
`else
  assign blanked = 1'b0;
`endif

  assign lit_limit = (32'(bright) + 32'd1) * 32'(REFRESH_DIV / 8);
  assign in_window = 32'(presc_q) < lit_limit;
  assign lit       = cur.en && in_window && !blanked;

  always_comb begin
    digits_d = digits_q;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_d[i].en = 1'b0;
    end else if (write && (int'(sel) < NUM_DIGITS)) begin
      digits_d[sel] = '{en: 1'b1, dp: dp_in, num: num};
    end

    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx_q + SEL_W'(1);
    end

    anode_ah = '0;
    if (lit) anode_ah[idx_q] = 1'b1;

    led_d = lit ? glyph : SEG_OFF;
    dp_d  = lit && cur.dp;
    seg_d = anode_ah;
    if (ACTIVE_LOW) begin
      led_d = ~led_d;
      dp_d  = ~dp_d;
      seg_d = ~seg_d;
    end
  end

  // NOTE: the digit store is a handful of flops, so it takes the async reset like the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= DIGIT_RESET;
      presc_q <= '0;
      idx_q   <= '0;
      led_q   <= {7{ACTIVE_LOW}};
      dp_q    <= ACTIVE_LOW;
      seg_q   <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, like real flops.
      digits_q <= digits_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      led_q    <= led_d;
      dp_q     <= dp_d;
      seg_q    <= seg_d;
    end
  end

  assign led     = led_q;
  assign dp      = dp_q;
  assign segment = seg_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl: 8-digit and 6-digit instances, REFRESH_DIV=8.
module tb_sevenseg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write = 1'b0;
  logic [2:0] sel = '0;
  logic [3:0] num = '0;
  logic       dp_in = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] bright = 3'd7;

  logic [6:0] led1, led2;
  logic       dp1, dp2;
  logic [7:0] seg1;
  logic [5:0] seg2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int onehot_err = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(8), .ACTIVE_LOW(1'b1)) dut8 (
    .clk(clk), .reset(rst), .write(write), .sel(sel), .num(num), .dp_in(dp_in),
    .clear(clear), .bright(bright), .led(led1), .dp(dp1), .segment(seg1)
  );

  sevenseg_scan_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(8), .ACTIVE_LOW(1'b1)) dut6 (
    .clk(clk), .reset(rst), .write(write), .sel(sel), .num(num), .dp_in(dp_in),
    .clear(clear), .bright(bright), .led(led2), .dp(dp2), .segment(seg2)
  );

  // Edges since reset release; after edge k the outputs show prescaler (k-1)%8 of slot (k-1)/8.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && $countones(~seg1) > 1) onehot_err <= onehot_err + 1;
  end

  typedef struct {
    int         slot;
    int         presc;
    logic [2:0] bright;
    logic [6:0] led;
    logic       dp;
    logic [7:0] seg;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge whose next posedge samples (slot,presc) = target of a period-long frame.
  task automatic goto(input int period, input int target);
    int n = 0;
    while ((cyc % period) != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL goto timeout: got cycle %0d expected phase %0d", cyc, target);
    end
  endtask

  task automatic wr(input logic [2:0] s, input logic [3:0] v, input logic d);
    write = 1'b1; sel = s; num = v; dp_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic count_lit8(input int ncyc, output int lit);
    lit = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (seg1 != 8'hFF) lit++;
    end
  endtask

  initial begin
    logic [3:0] wv [8];
    logic [6:0] lz_led [8];
    logic [7:0] lz_seg [8];
    int         lit;

    wv = '{4'h2, 4'h0, 4'h2, 4'h2, 4'hE, 4'hE, 4'h1, 4'h6};  // sel 7 down to 0

    vt[0]  = '{0, 0, 3'd7, 7'h02, 1'b1, 8'hFE};
    vt[1]  = '{1, 0, 3'd7, 7'h79, 1'b1, 8'hFD};
    vt[2]  = '{2, 0, 3'd7, 7'h06, 1'b1, 8'hFB};
    vt[3]  = '{3, 0, 3'd7, 7'h06, 1'b1, 8'hF7};
    vt[4]  = '{4, 0, 3'd7, 7'h24, 1'b1, 8'hEF};
    vt[5]  = '{5, 0, 3'd7, 7'h24, 1'b1, 8'hDF};
    vt[6]  = '{6, 0, 3'd7, 7'h40, 1'b1, 8'hBF};
    vt[7]  = '{7, 0, 3'd7, 7'h24, 1'b1, 8'h7F};
    vt[8]  = '{3, 7, 3'd7, 7'h06, 1'b1, 8'hF7};
    vt[9]  = '{3, 3, 3'd3, 7'h06, 1'b1, 8'hF7};
    vt[10] = '{3, 4, 3'd3, 7'h7F, 1'b1, 8'hFF};
    vt[11] = '{5, 0, 3'd0, 7'h24, 1'b1, 8'hDF};
    vt[12] = '{5, 1, 3'd0, 7'h7F, 1'b1, 8'hFF};

    // Reset state
    #12;
    check("reset_led", 32'(led1), 32'h7F);
    check("reset_dp", 32'(dp1), 32'h1);
    check("reset_seg8", 32'(seg1), 32'hFF);
    check("reset_seg6", 32'(seg2), 32'h3F);
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range sel on the 6-digit instance leaves it dark
    wr(3'd6, 4'h5, 1'b0);
    wr(3'd7, 4'h5, 1'b0);
    lit = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (seg2 != 6'h3F) lit++;
    end
    check("sel_oob_dark", 32'(lit), 32'd0);
    wr(3'd5, 4'h5, 1'b0);
    goto(48, 5 * 8);
    @(negedge clk);
    check("d6_slot5_seg", 32'(seg2), 32'h1F);
    check("d6_slot5_led", 32'(led2), 32'h12);

    // Main scan table
    for (int i = 0; i < 8; i++) wr(3'(7 - i), wv[i], 1'b0);
    for (int i = 0; i < 13; i++) begin
      goto(64, vt[i].slot * 8 + vt[i].presc);
      bright = vt[i].bright;
      @(negedge clk);
      check($sformatf("vec%0d_led", i), 32'(led1), 32'(vt[i].led));
      check($sformatf("vec%0d_dp", i), 32'(dp1), 32'(vt[i].dp));
      check($sformatf("vec%0d_seg", i), 32'(seg1), 32'(vt[i].seg));
    end

    // Brightness duty over one slot
    bright = 3'd3;
    goto(64, 2 * 8);
    count_lit8(8, lit);
    check("bright3_duty", 32'(lit), 32'd4);
    bright = 3'd0;
    goto(64, 2 * 8);
    count_lit8(8, lit);
    check("bright0_duty", 32'(lit), 32'd1);
    bright = 3'd7;

    // Reset in the middle of slot 5
    goto(64, 5 * 8 + 3);
    check("pre_reset_seg", 32'(seg1), 32'hDF);
    #2 rst = 1'b1;
    #1;
    check("async_reset_led", 32'(led1), 32'h7F);
    check("async_reset_dp", 32'(dp1), 32'h1);
    check("async_reset_seg", 32'(seg1), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    wr(3'd0, 4'h1, 1'b1);
    check("resume_first_dark", 32'(seg1), 32'hFF);
    @(negedge clk);
    check("resume_idx0_seg", 32'(seg1), 32'hFE);
    check("resume_idx0_led", 32'(led1), 32'h79);
    check("resume_idx0_dp", 32'(dp1), 32'h0);

    // Clear wins over a same-cycle write
    write = 1'b1; sel = 3'd3; num = 4'h9; clear = 1'b1;
    @(negedge clk);
    write = 1'b0; clear = 1'b0;
    count_lit8(64, lit);
    check("clear_all_dark", 32'(lit), 32'd0);

    // Leading zeros: digits 7..0 = 0,0,0,3,0,0,0,0
    for (int i = 0; i < 8; i++) wr(3'(7 - i), (i == 3) ? 4'h3 : 4'h0, 1'b0);
    lz_led = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40, 7'h40};
    lz_seg = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`ifdef SEVENSEG_LZ_BLANK_EN
    for (int s = 5; s < 8; s++) begin
      lz_led[s] = 7'h7F;
      lz_seg[s] = 8'hFF;
    end
`endif
    for (int s = 0; s < 8; s++) begin
      goto(64, s * 8);
      @(negedge clk);
      check($sformatf("lz_slot%0d_led", s), 32'(led1), 32'(lz_led[s]));
      check($sformatf("lz_slot%0d_seg", s), 32'(seg1), 32'(lz_seg[s]));
    end

    check("onehot_anode", 32'(onehot_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (multiple of 8, >= 8).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, 1 = segment and anode outputs active-low.
REQ-004 SHALL have derived localparam SEL_W = max(1, clog2(NUM_DIGITS)), the sel width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port write, input, 1 bit, write strobe for the digit register.
REQ-008 SHALL have port sel, input, SEL_W bits, digit index for writes; 0 = rightmost digit.
REQ-009 SHALL have port num, input, 4 bits, hex value to store.
REQ-010 SHALL have port dp_in, input, 1 bit, decimal point to store with num.
REQ-011 SHALL have port clear, input, 1 bit, synchronous disable of all digits.
REQ-012 SHALL have port bright, input, 3 bits, brightness level; 7 = full on.
REQ-013 SHALL have port led, output, 7 bits, segment drive {g,f,e,d,c,b,a}, led[0] = a.
REQ-014 SHALL have port dp, output, 1 bit, decimal point drive.
REQ-015 SHALL have port segment, output, NUM_DIGITS bits, one-hot anode select.

Function
REQ-016 SHALL hold per digit {en, dp, num[3:0]}; write=1 at a clk edge stores num and dp_in at digit sel and sets en.
REQ-017 SHALL ignore writes with sel >= NUM_DIGITS; no state change.
REQ-018 SHALL give clear priority over write in the same cycle; clear sets all en=0, keeps num and dp.
REQ-019 SHALL run prescaler 0..REFRESH_DIV-1, wrapping; at terminal count, scan index advances, wrapping NUM_DIGITS-1 -> 0.
REQ-020 SHALL register led, dp and segment: one cycle latency from index or prescaler to output.
REQ-021 SHALL make a write to the displayed digit visible on led on the second edge after the write edge.
REQ-022 SHALL decode hex, active-high gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-023 SHALL invert the decode, the dp level and the one-hot anode when ACTIVE_LOW=1.
REQ-024 SHALL light the slot only while prescaler < (bright+1)*(REFRESH_DIV/8); otherwise all anodes and segments are off.
REQ-025 SHALL drive a slot with en=0 as all off, anode off included.
REQ-026 SHALL assert at most one anode in any cycle.

Reset
REQ-027 SHALL asynchronously clear, on reset: prescaler=0, index=0, all en=0, num=0, dp=0.
REQ-028 SHALL force all outputs off during reset, ACTIVE_LOW=1 giving led=7F, dp=1, segment all ones.
REQ-029 SHALL resume scanning at index 0 with prescaler 0 on the first edge after reset falls, including reset mid-slot.

Configuration
REQ-030 SHALL implement leading-zero blanking when macro SEVENSEG_LZ_BLANK_EN is defined.
REQ-031 SHALL blank digit k when every digit from NUM_DIGITS-1 down to k has en=1, num=0 and dp=0 (macro defined).
REQ-032 SHALL never blank digit 0 (macro defined).
REQ-033 SHALL show zeros normally when the macro is undefined, with no blanking logic present.

Structure
REQ-034 SHALL place in package sevenseg_pkg: the 16-entry decode constant, the digit record typedef {en,dp,num} and the off-pattern constant.
REQ-035 SHALL place the hex to 7-segment decode in combinational sub-module sevenseg_hex_decode.

Verification
REQ-036 SHALL verify, NUM_DIGITS=8, REFRESH_DIV=8, bright=7: write sel 7..0 = 2,0,2,2,E,E,1,6 -> slots 0..7 show led 02,79,06,06,24,24,40,24, segment FE,FD,...,7F.
REQ-037 SHALL verify, NUM_DIGITS=6: write sel=6 num=5 -> register unchanged, all slots stay dark.
REQ-038 SHALL verify bright=3 -> anode active 4 of 8 cycles per slot; bright=0 -> 1 of 8.
REQ-039 SHALL verify reset asserted at index 5, prescaler 3 -> outputs off asynchronously; after release index 0 is lit after 1 cycle with en=0, so dark.
REQ-040 SHALL verify, with SEVENSEG_LZ_BLANK_EN, digits 7..0 = 0,0,0,3,0,0,0,0 -> digits 7..5 dark; 4 shows 3; digits 3..0 show 0.
REQ-041 SHALL verify write and clear in the same cycle -> all digits dark; the written num is retained.
